// File: rtl/rv_timer_multi_if.sv
// Register bus bundle for rv_timer_multi: single-cycle request, response one cycle later.
interface rv_timer_multi_if;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;
    logic        reg_rvalid_o;
    logic        reg_err_o;

    // Bus initiator (core side)
    modport master (
        output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
        input  reg_rdata_o, reg_rvalid_o, reg_err_o
    );

    // Timer block side
    modport slave (
        input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
        output reg_rdata_o, reg_rvalid_o, reg_err_o
    );
endinterface

// File: rtl/rv_timer_multi.sv
// Machine-timer block: one shared 64-bit mtime with prescaler/step and
// NumTimers independent 64-bit comparators with one-shot or auto-reload mode.
module rv_timer_multi #(
    parameter int unsigned NumTimers = 4,
    parameter int unsigned PrescaleW = 12,
    parameter int unsigned StepW     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rv_timer_multi_if.slave      bus,
    output logic [NumTimers-1:0] intr_o
);

    // Global registers
    logic                 r_active;
    logic [PrescaleW-1:0] r_prescale;
    logic [PrescaleW-1:0] r_presc_cnt;
    logic [StepW-1:0]     r_step;
    logic [63:0]          r_mtime;
    logic [NumTimers-1:0] r_intr_en;
    logic [NumTimers-1:0] r_intr_state;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;
    logic                 r_err;

    // Decode
    logic                 w_wr;
    logic [5:0]           w_word;
    logic [3:0]           w_slot;
    logic [1:0]           w_sub;
    logic                 w_is_timer;
    logic                 w_tick;
    logic                 w_wr_ctrl, w_wr_cfg, w_wr_mtlo, w_wr_mthi;
    logic                 w_wr_en, w_wr_state, w_wr_test;
    logic [NumTimers-1:0] w_sel_timer;
    logic [NumTimers-1:0] w_expired;
    logic [NumTimers-1:0] w_mode;
    logic [NumTimers-1:0][63:0] w_cmp;
    logic [NumTimers-1:0][31:0] w_period;
    logic [NumTimers-1:0] w_intr_set;
    logic [NumTimers-1:0] w_intr_clr;
    logic [31:0]          w_rdata;
    logic                 w_mapped;

    assign w_wr       = bus.reg_req_i & bus.reg_we_i;
    assign w_word     = bus.reg_addr_i[7:2];
    assign w_slot     = bus.reg_addr_i[7:4] - 4'd2;
    assign w_sub      = bus.reg_addr_i[3:2];
    assign w_is_timer = (bus.reg_addr_i[7:4] >= 4'd2) && (w_slot < 4'(NumTimers));

    assign w_wr_ctrl  = w_wr && (w_word == 6'h00);
    assign w_wr_cfg   = w_wr && (w_word == 6'h01);
    assign w_wr_mtlo  = w_wr && (w_word == 6'h02);
    assign w_wr_mthi  = w_wr && (w_word == 6'h03);
    assign w_wr_en    = w_wr && (w_word == 6'h04);
    assign w_wr_state = w_wr && (w_word == 6'h05);
    assign w_wr_test  = w_wr && (w_word == 6'h06);

    assign w_tick = r_active && (r_presc_cnt == r_prescale);

    // Per-timer comparator, reload logic and its software-visible registers
    generate
        for (genvar gi = 0; gi < NumTimers; gi++) begin : g_timer
            logic [63:0] r_cmp;
            logic [31:0] r_period;
            logic        r_mode;
            logic        w_reload;
            logic [63:0] w_cmp_next;

            assign w_sel_timer[gi] = w_is_timer && (w_slot == 4'(gi));
            assign w_expired[gi]   = r_mtime >= r_cmp;
            // PERIOD of zero degrades to one-shot level behaviour
            assign w_reload        = w_expired[gi] && r_mode && (r_period != 32'd0);
            assign w_cmp_next      = w_reload ? (r_cmp + 64'(r_period)) : r_cmp;
            assign w_cmp[gi]       = r_cmp;
            assign w_period[gi]    = r_period;
            assign w_mode[gi]      = r_mode;

            // Comparator/period/mode update; a software write beats the reload per half
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cmp    <= '1;
                    r_period <= '0;
                    r_mode   <= 1'b0;
                end else begin
                    r_cmp[31:0]  <= (w_wr && w_sel_timer[gi] && w_sub == 2'd0) ?
                                    bus.reg_wdata_i : w_cmp_next[31:0];
                    r_cmp[63:32] <= (w_wr && w_sel_timer[gi] && w_sub == 2'd1) ?
                                    bus.reg_wdata_i : w_cmp_next[63:32];
                    if (w_wr && w_sel_timer[gi] && w_sub == 2'd2) r_period <= bus.reg_wdata_i;
                    if (w_wr && w_sel_timer[gi] && w_sub == 2'd3) r_mode   <= bus.reg_wdata_i[0];
                end
            end
        end
    endgenerate

    // Control, prescaler and mtime; a bus write to one mtime half beats the tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active    <= 1'b0;
            r_prescale  <= '0;
            r_step      <= '0;
            r_presc_cnt <= '0;
            r_mtime     <= '0;
            r_intr_en   <= '0;
        end else begin
            if (w_wr_ctrl) r_active <= bus.reg_wdata_i[0];
            if (w_wr_cfg) begin
                r_prescale <= bus.reg_wdata_i[PrescaleW-1:0];
                r_step     <= bus.reg_wdata_i[16+StepW-1:16];
            end
            if (w_wr_en) r_intr_en <= bus.reg_wdata_i[NumTimers-1:0];
            r_presc_cnt <= (!r_active || w_tick) ? '0 : r_presc_cnt + 1'b1;
            if (w_wr_mtlo)      r_mtime[31:0]  <= bus.reg_wdata_i;
            else if (w_wr_mthi) r_mtime[63:32] <= bus.reg_wdata_i;
            else if (w_tick)    r_mtime        <= r_mtime + 64'(r_step);
        end
    end

    assign w_intr_set = w_expired | (w_wr_test ? bus.reg_wdata_i[NumTimers-1:0] : '0);
    assign w_intr_clr = w_wr_state ? bus.reg_wdata_i[NumTimers-1:0] : '0;

    // Sticky interrupt state: hardware set has priority over write-1-to-clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_intr_state <= '0;
        else         r_intr_state <= (r_intr_state & ~w_intr_clr) | w_intr_set;
    end

    // Read mux over current (pre-write) register values
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b0;
        case (w_word)
            6'h00: begin w_mapped = 1'b1; w_rdata = 32'(r_active); end
            6'h01: begin w_mapped = 1'b1; w_rdata = 32'(r_prescale) | (32'(r_step) << 16); end
            6'h02: begin w_mapped = 1'b1; w_rdata = r_mtime[31:0]; end
            6'h03: begin w_mapped = 1'b1; w_rdata = r_mtime[63:32]; end
            6'h04: begin w_mapped = 1'b1; w_rdata = 32'(r_intr_en); end
            6'h05: begin w_mapped = 1'b1; w_rdata = 32'(r_intr_state); end
            6'h06: begin w_mapped = 1'b1; w_rdata = '0; end
            default: ;
        endcase
        for (int i = 0; i < NumTimers; i++) begin
            if (w_sel_timer[i]) begin
                w_mapped = 1'b1;
                case (w_sub)
                    2'd0: w_rdata = w_cmp[i][31:0];
                    2'd1: w_rdata = w_cmp[i][63:32];
                    2'd2: w_rdata = w_period[i];
                    default: w_rdata = 32'(w_mode[i]);
                endcase
            end
        end
    end

    // Registered response, one cycle after every request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= bus.reg_req_i;
            r_err    <= bus.reg_req_i && !w_mapped;
            r_rdata  <= (bus.reg_req_i && !bus.reg_we_i) ? w_rdata : '0;
        end
    end

    assign bus.reg_rdata_o  = r_rdata;
    assign bus.reg_rvalid_o = r_rvalid;
    assign bus.reg_err_o    = r_err;
    assign intr_o           = r_intr_state & r_intr_en;

endmodule

// File: tb/tb_rv_timer_multi.sv
// Directed testbench for rv_timer_multi; bus tasks start and end on a falling edge.
module tb_rv_timer_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] intr;
    int         n_checks;
    int         n_fails;

    rv_timer_multi_if bus_if ();

    rv_timer_multi #(.NumTimers(4), .PrescaleW(12), .StepW(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if),
        .intr_o (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        bus_if.reg_req_i   = 1'b1;
        bus_if.reg_we_i    = 1'b1;
        bus_if.reg_addr_i  = addr;
        bus_if.reg_wdata_i = data;
        @(negedge clk);
        bus_if.reg_req_i   = 1'b0;
        bus_if.reg_we_i    = 1'b0;
        $display("wr addr=0x%02h data=0x%08h", addr, data);
    endtask

    task automatic read_check(input logic [7:0] addr, input logic [31:0] exp,
                              input logic exp_err, input string tag);
        bus_if.reg_req_i  = 1'b1;
        bus_if.reg_we_i   = 1'b0;
        bus_if.reg_addr_i = addr;
        @(negedge clk);
        bus_if.reg_req_i  = 1'b0;
        $display("rd addr=0x%02h data=0x%08h err=%0d", addr, bus_if.reg_rdata_o, bus_if.reg_err_o);
        check_eq({tag, ".rvalid"}, 64'(bus_if.reg_rvalid_o), 64'd1);
        check_eq(tag, 64'(bus_if.reg_rdata_o), 64'(exp));
        check_eq({tag, ".err"}, 64'(bus_if.reg_err_o), 64'(exp_err));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        n_checks = 0;
        n_fails  = 0;
        bus_if.reg_req_i   = 1'b0;
        bus_if.reg_we_i    = 1'b0;
        bus_if.reg_addr_i  = '0;
        bus_if.reg_wdata_i = '0;
        rst_n = 1'b0;

        // Power-on reset
        idle(2);
        check_eq("rst.rvalid", 64'(bus_if.reg_rvalid_o), 64'd0);
        check_eq("rst.rdata", 64'(bus_if.reg_rdata_o), 64'd0);
        check_eq("rst.intr", 64'(intr), 64'd0);
        rst_n = 1'b1;
        read_check(8'h08, 32'h0, 1'b0, "rst.mtime_lo");
        read_check(8'h0C, 32'h0, 1'b0, "rst.mtime_hi");
        read_check(8'h20, 32'hFFFF_FFFF, 1'b0, "rst.cmp0_lo");
        read_check(8'h24, 32'hFFFF_FFFF, 1'b0, "rst.cmp0_hi");
        read_check(8'h00, 32'h0, 1'b0, "rst.ctrl");

        // prescale=3, step=2, active for 40 edges -> 10 ticks
        bus_write(8'h04, 32'h0002_0003);
        read_check(8'h04, 32'h0002_0003, 1'b0, "cfg");
        bus_write(8'h00, 32'h1);
        idle(39);
        bus_write(8'h00, 32'h0);
        read_check(8'h08, 32'd20, 1'b0, "presc3.mtime");

        // prescale=0, step=1, active for 10 edges
        bus_write(8'h04, 32'h0001_0000);
        bus_write(8'h08, 32'h0);
        bus_write(8'h00, 32'h1);
        idle(9);
        bus_write(8'h00, 32'h0);
        read_check(8'h08, 32'd10, 1'b0, "presc0.mtime");

        // One-shot timer0 at 100 starting from mtime=90
        bus_write(8'h08, 32'd90);
        bus_write(8'h24, 32'h0);
        bus_write(8'h20, 32'd100);
        bus_write(8'h10, 32'h1);
        bus_write(8'h00, 32'h1);
        idle(10);
        check_eq("oneshot.intr_at_100", 64'(intr), 64'h0);
        idle(1);
        check_eq("oneshot.intr_after", 64'(intr), 64'h1);
        bus_write(8'h14, 32'h1);
        read_check(8'h14, 32'h1, 1'b0, "oneshot.reassert");
        bus_write(8'h20, 32'hFFFF_FFFF);
        bus_write(8'h24, 32'hFFFF_FFFF);
        bus_write(8'h14, 32'h1);
        read_check(8'h14, 32'h0, 1'b0, "oneshot.cleared");
        check_eq("oneshot.intr_low", 64'(intr), 64'h0);
        bus_write(8'h00, 32'h0);

        // Periodic timer1: CMP=50, PERIOD=25, mtime stepped by hand
        bus_write(8'h08, 32'h0);
        bus_write(8'h3C, 32'h1);
        bus_write(8'h38, 32'd25);
        bus_write(8'h34, 32'h0);
        bus_write(8'h30, 32'd50);
        bus_write(8'h10, 32'h3);
        for (int k = 0; k < 3; k++) begin
            v = 32'd50 + 32'(25 * k);
            bus_write(8'h14, 32'h2);
            read_check(8'h14, 32'h0, 1'b0, "periodic.pre_state");
            bus_write(8'h08, v);
            idle(1);
            read_check(8'h30, v + 32'd25, 1'b0, "periodic.cmp1");
            read_check(8'h14, 32'h2, 1'b0, "periodic.state");
            check_eq("periodic.intr", 64'(intr), 64'h2);
        end

        // mtime wrap: ..FFFE + 4 -> 2
        bus_write(8'h3C, 32'h0);
        bus_write(8'h30, 32'hFFFF_FFFF);
        bus_write(8'h34, 32'hFFFF_FFFF);
        bus_write(8'h04, 32'h0004_0000);
        bus_write(8'h08, 32'hFFFF_FFFE);
        bus_write(8'h0C, 32'hFFFF_FFFF);
        bus_write(8'h00, 32'h1);
        bus_write(8'h00, 32'h0);
        read_check(8'h08, 32'd2, 1'b0, "wrap.mtime_lo");
        read_check(8'h0C, 32'd0, 1'b0, "wrap.mtime_hi");

        // INTR_TEST, W1C, and expiry set beating W1C on bit2
        bus_write(8'h14, 32'hF);
        bus_write(8'h18, 32'h4);
        read_check(8'h14, 32'h4, 1'b0, "test.set");
        bus_write(8'h14, 32'h4);
        read_check(8'h14, 32'h0, 1'b0, "w1c.clear");
        read_check(8'h18, 32'h0, 1'b0, "test.reads0");
        bus_write(8'h44, 32'h0);
        bus_write(8'h40, 32'h0);
        bus_write(8'h14, 32'h4);
        read_check(8'h14, 32'h4, 1'b0, "set_beats_w1c");

        // Unmapped addresses and back-to-back reads
        read_check(8'hF0, 32'h0, 1'b1, "err.f0");
        read_check(8'h60, 32'h0, 1'b1, "err.no_timer4");
        read_check(8'h1C, 32'h0, 1'b1, "err.1c");
        read_check(8'h08, 32'd2, 1'b0, "b2b.mtime_lo");
        read_check(8'h0C, 32'd0, 1'b0, "b2b.mtime_hi");
        idle(1);
        check_eq("b2b.rvalid_drop", 64'(bus_if.reg_rvalid_o), 64'd0);

        // Reset mid-operation with a response and an interrupt pending
        bus_write(8'h10, 32'h4);
        check_eq("prerst.intr", 64'(intr), 64'h4);
        bus_write(8'h00, 32'h1);
        bus_if.reg_req_i  = 1'b1;
        bus_if.reg_we_i   = 1'b0;
        bus_if.reg_addr_i = 8'h08;
        @(posedge clk);
        #1;
        check_eq("prerst.rvalid", 64'(bus_if.reg_rvalid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst.rvalid", 64'(bus_if.reg_rvalid_o), 64'd0);
        check_eq("midrst.intr", 64'(intr), 64'h0);
        bus_if.reg_req_i = 1'b0;
        idle(2);
        rst_n = 1'b1;
        read_check(8'h08, 32'h0, 1'b0, "postrst.mtime_lo");
        read_check(8'h20, 32'hFFFF_FFFF, 1'b0, "postrst.cmp0_lo");
        read_check(8'h14, 32'h0, 1'b0, "postrst.state");
        read_check(8'h00, 32'h0, 1'b0, "postrst.ctrl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
